detector_jogada: RTL

Input-conditioning stage directly upstream of the game data path. It synchronizes and debounces the player's key inputs, qualifies a stable press, and delivers the registered key code with a single-cycle "jogada feita" strobe. This strobe is what the control unit's jogada input consumes. A press yields exactly one strobe, regardless of bounce or hold time.

---
 rtl/detector_jogada.sv | 116 +++++++++++
 1 files changed

// File: rtl/detector_jogada.sv
// detector_jogada: 2-FF sync, debounce and one-shot strobe for player keys.
// Optional MULTIKEY_REJECT_EN: only one-hot key patterns start a press.
module detector_jogada #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] chaves,
  input  logic             limpa,
  output logic             jogada_feita,
  output logic [WIDTH-1:0] jogada,
  output logic             tem_jogada,
  output logic [3:0]       db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  localparam logic [2:0] OCIOSO       = 3'd0;
  localparam logic [2:0] ESTAB_PRESS  = 3'd1;
  localparam logic [2:0] ACEITA       = 3'd2;
  localparam logic [2:0] ESPERA_SOLTA = 3'd3;
  localparam logic [2:0] ESTAB_SOLTA  = 3'd4;

  logic [WIDTH-1:0] s_meta;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand;
  logic [2:0]       estado;
  logic [2:0]       prox;
  logic [CW-1:0]    cnt;
  logic             s_ok;

`ifdef MULTIKEY_REJECT_EN
  assign s_ok = (s != '0) && ((s & (s - WIDTH'(1))) == '0);
`else
  assign s_ok = (s != '0);
`endif

  assign db_estado = {1'b0, estado};

  // two-flop synchronizer on the raw keys
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_meta <= '0;
      s      <= '0;
    end else begin
      s_meta <= chaves;
      s      <= s_meta;
    end
  end

  // next-state decode of the debounce FSM
  always_comb begin
    prox = estado;
    unique case (1'b1)
      (estado == OCIOSO): begin
        if (s_ok) prox = ESTAB_PRESS;
      end
      (estado == ESTAB_PRESS): begin
        if (s != cand)
          prox = OCIOSO;
        else if (cnt == CNT_LAST)
          prox = ACEITA;
      end
      (estado == ACEITA): begin
        prox = ESPERA_SOLTA;
      end
      (estado == ESPERA_SOLTA): begin
        if (s == '0) prox = ESTAB_SOLTA;
      end
      (estado == ESTAB_SOLTA): begin
        if (s != '0)
          prox = ESPERA_SOLTA;
        else if (cnt == CNT_LAST)
          prox = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  // state, candidate key, stability counter and strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      cand         <= '0;
      cnt          <= '0;
      jogada_feita <= 1'b0;
    end else begin
      estado       <= prox;
      jogada_feita <= (prox == ACEITA);
      if (estado == OCIOSO && prox == ESTAB_PRESS)
        cand <= s;
      if (prox != estado)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  // accepted code register; a new accept beats limpa
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogada     <= '0;
      tem_jogada <= 1'b0;
    end else if (prox == ACEITA) begin
      jogada     <= cand;
      tem_jogada <= 1'b1;
    end else if (limpa && estado != ACEITA) begin
      jogada     <= '0;
      tem_jogada <= 1'b0;
    end
  end

endmodule
